string_line_renderer: RTL and testbench

Draws or erases one string (pin-to-pin line) on the canvas framebuffer for each edge operation produced by the edge search engine. Sits directly downstream of the search engine: its request port connects to the engine's result handshake (pin pair plus add/remove flag). It converts the pin indices to canvas coordinates, rasterises the line with integer Bresenham, and streams pixel writes to the framebuffer arbiter under valid/ready backpressure. It also keeps a running count of strings currently on the canvas.

---
 rtl/string_art_pkg.sv | 23 ++
 rtl/Pin_pos_memory.sv | 35 +++
 rtl/line_stepper.sv | 101 ++++++++++
 rtl/string_line_renderer.sv | 150 +++++++++++++++
 tb/tb_string_line_renderer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/string_art_pkg.sv
// Shared widths, renderer state encoding and pin-position word layout
// for the string-art datapath.
package string_art_pkg;

    localparam int PIN_W   = 8;
    localparam int COORD_W = 9;
    localparam int CNT_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_DRAW,
        ST_DONE
    } render_state_e;

    // Position ROM word: {y, x}
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pin_pos_t;

endpackage

// File: rtl/Pin_pos_memory.sv
// Pin position lookup table with a registered read port (one cycle latency).
// Contents come from INIT_DATA, entry i at bits [i*DATA_WIDTH +: DATA_WIDTH].
module Pin_pos_memory #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 8,
    parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INIT_DATA = '0
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom [DEPTH];
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom[gi] = INIT_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        data_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/line_stepper.sv
// Integer Bresenham walker: load latches both endpoints, each step advances
// one pixel toward (x1,y1); done flags that the current point is the endpoint.
module line_stepper #(
    parameter int COORD_W = string_art_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               done
);

    localparam int EW = COORD_W + 2;

    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]   x_end_q, x_end_d, y_end_q, y_end_d;
    logic [COORD_W-1:0]   dx_q, dx_d, dy_mag_q, dy_mag_d;
    logic                 x_neg_q, x_neg_d, y_neg_q, y_neg_d;
    logic signed [EW-1:0] err_q, err_d;

    logic [COORD_W-1:0]   dx_new, dy_new;
    logic signed [EW-1:0] dx_s, dy_s;
    logic signed [EW:0]   e2;
    logic                 move_x, move_y;

    assign done = (x_q == x_end_q) && (y_q == y_end_q);
    assign x    = x_q;
    assign y    = y_q;

    always_comb begin
        dx_new = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        dy_new = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        dx_s   = signed'({2'b00, dx_q});
        dy_s   = -signed'({2'b00, dy_mag_q});
        e2     = signed'({err_q, 1'b0});
        // Both decisions use the error term from before this step
        move_x = (e2 >= signed'({dy_s[EW-1], dy_s}));
        move_y = (e2 <= signed'({dx_s[EW-1], dx_s}));

        x_d      = x_q;
        y_d      = y_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        dx_d     = dx_q;
        dy_mag_d = dy_mag_q;
        x_neg_d  = x_neg_q;
        y_neg_d  = y_neg_q;
        err_d    = err_q;

        if (load) begin
            x_d      = x0;
            y_d      = y0;
            x_end_d  = x1;
            y_end_d  = y1;
            dx_d     = dx_new;
            dy_mag_d = dy_new;
            x_neg_d  = (x1 < x0);
            y_neg_d  = (y1 < y0);
            err_d    = signed'({2'b00, dx_new}) - signed'({2'b00, dy_new});
        end else if (step && !done) begin
            err_d = err_q + (move_x ? dy_s : '0) + (move_y ? dx_s : '0);
            if (move_x) begin
                x_d = x_neg_q ? (x_q - 1'b1) : (x_q + 1'b1);
            end
            if (move_y) begin
                y_d = y_neg_q ? (y_q - 1'b1) : (y_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q      <= '0;
            y_q      <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
            dx_q     <= '0;
            dy_mag_q <= '0;
            x_neg_q  <= 1'b0;
            y_neg_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            dx_q     <= dx_d;
            dy_mag_q <= dy_mag_d;
            x_neg_q  <= x_neg_d;
            y_neg_q  <= y_neg_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/string_line_renderer.sv
// Draws or erases one pin-to-pin string per request: pin lookup, Bresenham
// rasterisation and pixel streaming under valid/ready, plus a string counter.
module string_line_renderer
    import string_art_pkg::*;
#(
    parameter int PIN_W   = string_art_pkg::PIN_W,
    parameter int COORD_W = string_art_pkg::COORD_W,
    parameter int CNT_W   = string_art_pkg::CNT_W,
    parameter logic [(2**PIN_W)*2*COORD_W-1:0] POS_TABLE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [PIN_W-1:0]   req_pin_1,
    input  logic [PIN_W-1:0]   req_pin_2,
    input  logic               req_remove,
    output logic               pix_val,
    input  logic               pix_rdy,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_data,
    output logic               line_done,
    output logic [CNT_W-1:0]   string_count
);

    render_state_e      state_q, state_d;
    logic [PIN_W-1:0]   pin_1_q, pin_1_d, pin_2_q, pin_2_d;
    logic               remove_q, remove_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [2*COORD_W-1:0] pos_1_word, pos_2_word;
    logic [COORD_W-1:0]   pos_1_x, pos_1_y, pos_2_x, pos_2_y;
    logic                 load, step, at_end;

    Pin_pos_memory #(
        .DATA_WIDTH (2*COORD_W),
        .ADDR_WIDTH (PIN_W),
        .INIT_DATA  (POS_TABLE)
    ) u_pos_1 (
        .clk  (clk),
        .addr (pin_1_q),
        .data (pos_1_word)
    );

    Pin_pos_memory #(
        .DATA_WIDTH (2*COORD_W),
        .ADDR_WIDTH (PIN_W),
        .INIT_DATA  (POS_TABLE)
    ) u_pos_2 (
        .clk  (clk),
        .addr (pin_2_q),
        .data (pos_2_word)
    );

    // ROM word layout is {y, x}
    assign {pos_1_y, pos_1_x} = pos_1_word;
    assign {pos_2_y, pos_2_x} = pos_2_word;

    line_stepper #(
        .COORD_W (COORD_W)
    ) u_stepper (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .x0    (pos_1_x),
        .y0    (pos_1_y),
        .x1    (pos_2_x),
        .y1    (pos_2_y),
        .x     (pix_x),
        .y     (pix_y),
        .done  (at_end)
    );

    assign string_count = count_q;

    always_comb begin
        state_d   = state_q;
        pin_1_d   = pin_1_q;
        pin_2_d   = pin_2_q;
        remove_d  = remove_q;
        count_d   = count_q;
        req_rdy   = 1'b0;
        pix_val   = 1'b0;
        pix_data  = 1'b0;
        line_done = 1'b0;
        load      = 1'b0;
        step      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    pin_1_d  = req_pin_1;
                    pin_2_d  = req_pin_2;
                    remove_d = req_remove;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                load    = 1'b1;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                pix_val  = 1'b1;
                pix_data = ~remove_q;
                if (pix_rdy) begin
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                line_done = 1'b1;
                if (remove_q) begin
                    count_d = (count_q == '0) ? count_q : (count_q - 1'b1);
                end else begin
                    count_d = (&count_q) ? count_q : (count_q + 1'b1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pin_1_q  <= '0;
            pin_2_q  <= '0;
            remove_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pin_1_q  <= pin_1_d;
            pin_2_q  <= pin_2_d;
            remove_q <= remove_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_string_line_renderer.sv
// Directed bench for string_line_renderer: small pin table, hand-computed
// pixel sequences, backpressure, counter saturation at zero and mid-line reset.
module tb_string_line_renderer;

    localparam int PIN_W   = 8;
    localparam int COORD_W = 9;
    localparam int CNT_W   = 12;
    localparam int TW      = 256 * 18;

    function automatic logic [TW-1:0] make_table();
        logic [TW-1:0] t;
        t = '0;
        t[1*18 +: 18] = {9'd0,  9'd0};
        t[2*18 +: 18] = {9'd3,  9'd3};
        t[3*18 +: 18] = {9'd20, 9'd10};
        t[4*18 +: 18] = {9'd0,  9'd5};
        t[5*18 +: 18] = {9'd4,  9'd6};
        t[7*18 +: 18] = {9'd20, 9'd14};
        return t;
    endfunction

    localparam logic [TW-1:0] TB_POS = make_table();

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               req_val = 1'b0;
    logic               req_rdy;
    logic [PIN_W-1:0]   req_pin_1 = '0;
    logic [PIN_W-1:0]   req_pin_2 = '0;
    logic               req_remove = 1'b0;
    logic               pix_val;
    logic               pix_rdy = 1'b0;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_data;
    logic               line_done;
    logic [CNT_W-1:0]   string_count;

    int checks = 0;
    int errors = 0;
    int exp_x [8];
    int exp_y [8];

    always #5 clk = ~clk;

    string_line_renderer #(
        .PIN_W     (PIN_W),
        .COORD_W   (COORD_W),
        .CNT_W     (CNT_W),
        .POS_TABLE (TB_POS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_pin_1    (req_pin_1),
        .req_pin_2    (req_pin_2),
        .req_remove   (req_remove),
        .pix_val      (pix_val),
        .pix_rdy      (pix_rdy),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .line_done    (line_done),
        .string_count (string_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int i, input int x, input int y);
        exp_x[i] = x;
        exp_y[i] = y;
    endtask

    // Presents one request at a negedge; returns at the negedge of cycle T+1.
    task automatic send(input int p1, input int p2, input logic rem);
        chk("send req_rdy", req_rdy, 1);
        req_val    = 1'b1;
        req_pin_1  = PIN_W'(p1);
        req_pin_2  = PIN_W'(p2);
        req_remove = rem;
        @(negedge clk);
        req_val = 1'b0;
        $display("request pins (%0d,%0d) remove=%0b accepted", p1, p2, rem);
    endtask

    // Collects n pixels against exp_x/exp_y, optionally stalling 3 cycles at stall_idx.
    task automatic render(input string name, input int n, input logic data,
                          input int stall_idx, input int exp_cnt);
        int got;
        int stall;
        int guard;
        got = 0;
        stall = 0;
        guard = 0;
        chk({name, " lat1 pix_val"}, pix_val, 0);
        chk({name, " lat1 req_rdy"}, req_rdy, 0);
        @(negedge clk);
        chk({name, " lat2 pix_val"}, pix_val, 0);
        @(negedge clk);
        while (got < n && guard < 100) begin
            guard++;
            chk($sformatf("%s pix_val[%0d]", name, got), pix_val, 1);
            chk($sformatf("%s x[%0d]", name, got), pix_x, exp_x[got]);
            chk($sformatf("%s y[%0d]", name, got), pix_y, exp_y[got]);
            chk($sformatf("%s data[%0d]", name, got), pix_data, data);
            chk($sformatf("%s req_rdy[%0d]", name, got), req_rdy, 0);
            if (got == stall_idx && stall < 3) begin
                pix_rdy = 1'b0;
                stall++;
            end else begin
                pix_rdy = 1'b1;
                got++;
            end
            @(negedge clk);
        end
        pix_rdy = 1'b0;
        chk({name, " pixel count"}, got, n);
        chk({name, " line_done"}, line_done, 1);
        chk({name, " no extra pixel"}, pix_val, 0);
        @(negedge clk);
        chk({name, " line_done pulse"}, line_done, 0);
        chk({name, " req_rdy back"}, req_rdy, 1);
        chk({name, " string_count"}, string_count, exp_cnt);
        $display("line %s: %0d pixels, data=%0b, count=%0d", name, got, data, string_count);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst pix_val", pix_val, 0);
        chk("rst pix_x", pix_x, 0);
        chk("rst pix_y", pix_y, 0);
        chk("rst pix_data", pix_data, 0);
        chk("rst line_done", line_done, 0);
        chk("rst count", string_count, 0);
        chk("rst req_rdy", req_rdy, 1);
        reset = 1'b1;
        @(negedge clk);
        $display("reset released");

        // Horizontal line with a 3-cycle stall on the second pixel
        for (int i = 0; i < 5; i++) set_exp(i, 10 + i, 20);
        send(3, 7, 1'b0);
        render("add37", 5, 1'b1, 1, 1);

        // Erase the same line, then erase again with the counter at zero
        send(3, 7, 1'b1);
        render("rem37", 5, 1'b0, -1, 0);
        send(3, 7, 1'b1);
        render("rem37_sat", 5, 1'b0, -1, 0);

        // Diagonal drawn toward the origin
        set_exp(0, 3, 3);
        set_exp(1, 2, 2);
        set_exp(2, 1, 1);
        set_exp(3, 0, 0);
        send(2, 1, 1'b0);
        render("add21", 4, 1'b1, -1, 1);

        // Steep line (5,0) -> (6,4)
        set_exp(0, 5, 0);
        set_exp(1, 5, 1);
        set_exp(2, 6, 2);
        set_exp(3, 6, 3);
        set_exp(4, 6, 4);
        send(4, 5, 1'b0);
        render("add45", 5, 1'b1, -1, 2);

        // Equal pins give exactly one pixel
        set_exp(0, 10, 20);
        send(3, 3, 1'b0);
        render("add33", 1, 1'b1, -1, 3);

        // Reset in the middle of a line
        send(4, 5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst pix_val before", pix_val, 1);
        pix_rdy = 1'b1;
        @(negedge clk);
        chk("midrst second pixel y", pix_y, 1);
        pix_rdy = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst pix_val", pix_val, 0);
        chk("midrst count", string_count, 0);
        chk("midrst req_rdy", req_rdy, 1);
        chk("midrst line_done", line_done, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst idle pix_val", pix_val, 0);
        $display("mid-line reset applied");

        // Normal rendering after the reset
        for (int i = 0; i < 5; i++) set_exp(i, 10 + i, 20);
        send(3, 7, 1'b0);
        render("post_rst37", 5, 1'b1, -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
